// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side flywheel for a VGA sync stream. Samples active-low hsync/vsync
//   on each pixel strobe, aligns a local (hcount, vcount) pair to the first
//   vsync-qualified hsync fall, checks every later strobe against the expected
//   sync windows and declares lock after LOCK_FRAMES clean frame wraps.
//
//   Ports
//     clk          system clock
//     reset        asynchronous, active-low reset
//     pix_en       one-cycle pixel strobe; nothing advances without it
//     hsync_n      horizontal sync, active low, same clock domain
//     vsync_n      vertical sync, active low, same clock domain
//     pixel_x      recovered column, 0..H_TOTAL-1
//     pixel_y      recovered row, 0..V_TOTAL-1
//     video_on     locked and inside the visible area
//     locked       high while in LOCKED
//     frame_start  one-clk pulse on the (0,0) strobe while locked
//     timing_err   one-clk pulse on a sync mismatch in ACQUIRE or LOCKED
module vga_sync_decoder #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_en,
   input  logic       hsync_n,
   input  logic       vsync_n,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       locked,
   output logic       frame_start,
   output logic       timing_err
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

   state_e     state_q, state_d;
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic [3:0] frame_cnt_q, frame_cnt_d;
   logic       hs_prev_q, hs_prev_d;
   logic       vs_line_prev_q, vs_line_prev_d;
   logic       video_on_q, video_on_d;
   logic       frame_start_q, frame_start_d;
   logic       timing_err_q, timing_err_d;

   // ---------------------------------------------------------------------
   // Counter datapath: free-running increment, SEARCH-only realignment,
   // and the sync-window checks on the resulting "new" position.
   // ---------------------------------------------------------------------
   logic       h_wrap;
   logic [9:0] h_inc, v_inc, h_new, v_new;
   logic       hs_fall, vs_fall;
   logic       in_hs, in_vs, mismatch, at_origin;
   logic [3:0] frame_cnt_inc;

   always_comb begin
      h_wrap  = (hcnt_q == H_LAST);
      h_inc   = h_wrap ? 10'd0 : hcnt_q + 10'd1;
      v_inc   = h_wrap ? ((vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1) : vcnt_q;
      hs_fall = ~hsync_n & hs_prev_q;
      vs_fall = ~vsync_n & vs_line_prev_q;

      h_new = h_inc;
      v_new = v_inc;
      if (state_q == SEARCH && hs_fall) begin
         h_new = HS_START;
         if (vs_fall)
            v_new = VS_START;
      end

      in_hs = (h_new >= HS_START) && (h_new <= HS_END);
      in_vs = (v_new >= VS_START) && (v_new <= VS_END);
      // vsync is only judged on the strobe where hsync should start
      mismatch = (state_q != SEARCH) &&
                 ((hsync_n == in_hs) || ((h_new == HS_START) && (vsync_n == in_vs)));
      at_origin     = (h_new == 10'd0) && (v_new == 10'd0);
      frame_cnt_inc = frame_cnt_q + 4'd1;
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SEARCH;
         frame_cnt_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state. A mismatch wins over lock promotion.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      if (pix_en) begin
         case (state_q)
            SEARCH: begin
               if (hs_fall && vs_fall) begin
                  state_d     = ACQUIRE;
                  frame_cnt_d = 4'd0;
               end
            end
            ACQUIRE: begin
               if (mismatch) begin
                  state_d = SEARCH;
               end else if (at_origin) begin
                  frame_cnt_d = frame_cnt_inc;
                  if (frame_cnt_inc == LOCK_N)
                     state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (mismatch)
                  state_d = SEARCH;
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FSM: outputs and datapath next values. Level outputs hold between
   // strobes; the two pulses clear on any non-strobe cycle.
   // ---------------------------------------------------------------------
   always_comb begin
      hcnt_d         = hcnt_q;
      vcnt_d         = vcnt_q;
      hs_prev_d      = hs_prev_q;
      vs_line_prev_d = vs_line_prev_q;
      video_on_d     = video_on_q;
      frame_start_d  = 1'b0;
      timing_err_d   = 1'b0;
      if (pix_en) begin
         hcnt_d    = h_new;
         vcnt_d    = v_new;
         hs_prev_d = hsync_n;
         if (hs_fall)
            vs_line_prev_d = vsync_n;
         // keyed on state_d so a drop-out clears video_on with timing_err
         video_on_d    = (state_d == LOCKED) && (h_new < H_VIS) && (v_new < V_VIS);
         frame_start_d = (state_d == LOCKED) && at_origin;
         timing_err_d  = mismatch;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcnt_q         <= 10'd0;
         vcnt_q         <= 10'd0;
         hs_prev_q      <= 1'b1;
         vs_line_prev_q <= 1'b1;
         video_on_q     <= 1'b0;
         frame_start_q  <= 1'b0;
         timing_err_q   <= 1'b0;
      end else begin
         hcnt_q         <= hcnt_d;
         vcnt_q         <= vcnt_d;
         hs_prev_q      <= hs_prev_d;
         vs_line_prev_q <= vs_line_prev_d;
         video_on_q     <= video_on_d;
         frame_start_q  <= frame_start_d;
         timing_err_q   <= timing_err_d;
      end
   end

   assign pixel_x     = hcnt_q;
   assign pixel_y     = vcnt_q;
   assign locked      = (state_q == LOCKED);
   assign video_on    = video_on_q;
   assign frame_start = frame_start_q;
   assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder, run on a reduced 32x15 raster so lock is
// reached in a few hundred strobes. A generator produces the sync stream
// with optional faults; the expected outputs come from the generator's own
// position plus the alignment / lock-latency rules.
module tb_vga_sync_decoder;
   localparam int HV = 16, HF = 4, HS = 6, HB = 6;
   localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
   localparam int LF = 2;
   localparam int HT  = HV + HF + HS + HB;
   localparam int VT  = VV + VF + VS + VB;
   localparam int HSS = HV + HF;
   localparam int HSE = HSS + HS - 1;
   localparam int VSS = VV + VF;
   localparam int VSE = VSS + VS - 1;
   localparam int FRAME = HT * VT;
   // strobes from aligning fall (HSS,VSS) to the LF-th (0,0)
   localparam int LAT = (HT - HSS) + (VT - VSS - 1) * HT + (LF - 1) * FRAME;

   logic       clk = 1'b0;
   logic       reset, pix_en, hsync_n, vsync_n;
   logic [9:0] pixel_x, pixel_y;
   logic       video_on, locked, frame_start, timing_err;

   always #5 clk = ~clk;

   vga_sync_decoder #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .LOCK_FRAMES(LF)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .hsync_n(hsync_n), .vsync_n(vsync_n),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
      .locked(locked), .frame_start(frame_start), .timing_err(timing_err)
   );

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // generator state and fault controls
   int gh, gv;
   bit short_req, narrow_req, vs_wide;
   bit short_pend, narrow_hit, desync;
   // reference state
   bit aligned;
   int sa, sidx, align_idx, lock_idx, te_cnt, von_cnt, last_fs, mode;
   bit prev_lock, lock_seen;
   bit e_err, e_lock, e_fs, e_von;

   task automatic gen_advance();
      if (short_req && gh == HT - 2) begin
         gh = 0; gv = (gv + 1) % VT;
         short_req = 0; short_pend = 1; desync = 1;
      end else begin
         gh++;
         if (gh == HT) begin gh = 0; gv = (gv + 1) % VT; end
      end
      hsync_n = !(gh >= HSS && gh <= HSE);
      if (narrow_req && gh == HSE) begin
         hsync_n = 1'b1; narrow_req = 0; narrow_hit = 1;
      end
      vsync_n = !(gv >= VSS && gv <= (vs_wide ? VSE + 1 : VSE));
   endtask

   task automatic model();
      bit err_raw;
      err_raw = 0;
      if (short_pend && gh == HSS) begin err_raw = 1; short_pend = 0; end
      if (narrow_hit) begin err_raw = 1; narrow_hit = 0; end
      if (vs_wide && gh == HSS && gv == VSS + 2) err_raw = 1;
      e_err = err_raw && aligned;
      if (e_err) aligned = 0;
      else if (!aligned && gh == HSS && gv == VSS) begin
         aligned = 1; sa = 0; desync = 0; align_idx = sidx;
      end else if (aligned) sa++;
      e_lock = aligned && sa >= LAT;
      e_fs   = e_lock && gh == 0 && gv == 0;
      e_von  = e_lock && gh < HV && gv < VV;
   endtask

   task automatic strobe();
      int idle;
      idle = (mode == 0) ? 4 : (mode == 1) ? int'($urandom_range(0, 3)) : 0;
      for (int i = 0; i < idle; i++) begin
         pix_en = 1'b0;
         @(negedge clk);
         chk("pulse_width", {30'd0, frame_start, timing_err}, 32'd0);
      end
      sidx++;
      pix_en = 1'b1;
      gen_advance();
      model();
      @(negedge clk);
      pix_en = 1'b0;
      chk("flags", {28'd0, video_on, locked, frame_start, timing_err},
          {28'd0, e_von, e_lock, e_fs, e_err});
      if (aligned && !desync)
         chk("pos", {12'd0, pixel_x, pixel_y}, {12'd0, 10'(gh), 10'(gv)});
      if (locked && !prev_lock) lock_idx = sidx;
      prev_lock = locked;
      lock_seen |= locked;
      if (timing_err) te_cnt++;
      if (video_on) von_cnt++;
      if (!locked) last_fs = -1;
      if (frame_start) begin
         if (last_fs >= 0) chk("fs_period", sidx - last_fs, FRAME);
         last_fs = sidx;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) strobe();
   endtask

   initial begin
      reset = 1'b0; pix_en = 1'b0;
      gh = int'($urandom_range(0, HSS - 1));
      gv = int'($urandom_range(0, VSS - 1));
      hsync_n = 1'b1; vsync_n = 1'b1;
      aligned = 0; desync = 0; sidx = 0; te_cnt = 0; von_cnt = 0;
      last_fs = -1; prev_lock = 0; lock_idx = -1; align_idx = 0;
      repeat (3) @(negedge clk);
      chk("reset_state", {10'd0, pixel_x, pixel_y, video_on, locked, frame_start, timing_err}, 32'd0);
      reset = 1'b1;

      // A: clean stream, strobe every 5th clk
      mode = 0;
      run(FRAME + LAT + 10);
      chk("A_locked", {31'd0, locked}, 32'd1);
      chk("A_lock_lat", lock_idx - align_idx, LAT);
      von_cnt = 0;
      run(FRAME);
      chk("A_von_frame", von_cnt, HV * VV);
      chk("A_no_err", te_cnt, 0);

      // B: one line a pixel short, random strobe cadence
      mode = 1;
      for (int i = 0; i < 2 * FRAME && !(gv == 8 && gh == 0); i++) strobe();
      short_req = 1; te_cnt = 0;
      run(2 * FRAME + LAT);
      chk("B_err_count", te_cnt, 1);
      chk("B_relocked", {31'd0, locked}, 32'd1);
      chk("B_lock_lat", lock_idx - align_idx, LAT);

      // C: hsync one pixel narrow while locked
      narrow_req = 1; te_cnt = 0;
      run(2 * FRAME + LAT);
      chk("C_err_count", te_cnt, 1);
      chk("C_relocked", {31'd0, locked}, 32'd1);

      // D: vsync three lines wide during ACQUIRE
      narrow_req = 1; te_cnt = 0;
      for (int i = 0; i < FRAME && aligned; i++) strobe();
      for (int i = 0; i < 2 * FRAME && !aligned; i++) strobe();
      for (int i = 0; i < FRAME && !(gv == 0 && gh == 0); i++) strobe();
      vs_wide = 1; lock_seen = 0;
      for (int i = 0; i < FRAME && gv != VSS + 3; i++) strobe();
      vs_wide = 0;
      chk("D_err_count", te_cnt, 2);
      chk("D_no_lock", {31'd0, lock_seen}, 32'd0);
      run(2 * FRAME + LAT);
      chk("D_relocked", {31'd0, locked}, 32'd1);

      // E: async reset mid-line while locked, then pix_en tied high
      mode = 0;
      for (int i = 0; i < 2 * FRAME && !(gh == 5 && gv == 3); i++) strobe();
      chk("E_pre_locked", {31'd0, locked}, 32'd1);
      #2 reset = 1'b0;
      #1 chk("E_reset_async", {10'd0, pixel_x, pixel_y, video_on, locked, frame_start, timing_err}, 32'd0);
      aligned = 0; desync = 0; prev_lock = 0; last_fs = -1;
      repeat (3) @(negedge clk);
      chk("E_reset_hold", {10'd0, pixel_x, pixel_y, video_on, locked, frame_start, timing_err}, 32'd0);
      reset = 1'b1;
      mode = 2; te_cnt = 0;
      run(FRAME + LAT + 10);
      chk("E_relocked", {31'd0, locked}, 32'd1);
      chk("E_lock_lat", lock_idx - align_idx, LAT);
      chk("E_no_err", te_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
